// File: rtl/sump_response_sender.sv
`default_nettype none
// ============================================================================
// Module   : sump_response_sender
// Brief    : Streams SUMP/OLS ID, metadata or WORD responses into a UART TX,
//            one byte per handshake. Macro SUMP_WORD_RESP_EN enables WORD mode.
// Revision : 1.0 - initial release
// ============================================================================
module sump_response_sender #(
  parameter int SAMPLE_DEPTH    = 32768,
  parameter int MAX_SAMPLE_RATE = 200000000,
  parameter int NUM_PROBES      = 8,
  parameter int PROTOCOL_VER    = 2,
  parameter int WORD_BYTES      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  resp_sel,
  input  logic [31:0] word_in,
  input  logic        abort,
  input  logic        tx_busy,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEND  = 3'd1;
  localparam logic [2:0] ST_ACK   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam logic [1:0] RESP_ID   = 2'd0;
  localparam logic [1:0] RESP_META = 2'd1;
  localparam logic [1:0] RESP_WORD = 2'd2;

  localparam logic [31:0] DEPTH_W  = 32'(SAMPLE_DEPTH);
  localparam logic [31:0] RATE_W   = 32'(MAX_SAMPLE_RATE);
  localparam logic [7:0]  PROBES_B = 8'(NUM_PROBES);
  localparam logic [7:0]  PROTO_B  = 8'(PROTOCOL_VER);

  logic [2:0] state;
  logic [1:0] sel;
  logic [4:0] index;
  logic       abort_pending;
  logic [7:0] content;
  logic [4:0] last_index;
  logic       req_valid;

`ifdef SUMP_WORD_RESP_EN
  logic [31:0] word_reg;
  assign req_valid = (resp_sel == RESP_ID) || (resp_sel == RESP_META) || (resp_sel == RESP_WORD);
`else
  logic unused_word;
  assign unused_word = ^word_in;
  assign req_valid = (resp_sel == RESP_ID) || (resp_sel == RESP_META);
`endif

  // Response bytes are derived from parameters and the index; no stored table.
  always_comb begin
    content = 8'h00;
    case (sel)
      RESP_ID: begin
        case (index)
          5'd0:    content = 8'h41;
          5'd1:    content = 8'h43;
          5'd2:    content = 8'h53;
          5'd3:    content = 8'h50;
          default: content = 8'h00;
        endcase
      end
      RESP_META: begin
        case (index)
          5'd0:    content = 8'h01;
          5'd1:    content = 8'h41;
          5'd2:    content = 8'h43;
          5'd3:    content = 8'h53;
          5'd4:    content = 8'h50;
          5'd5:    content = 8'h00;
          5'd6:    content = 8'h02;
          5'd7:    content = 8'h31;
          5'd8:    content = 8'h2E;
          5'd9:    content = 8'h30;
          5'd10:   content = 8'h30;
          5'd11:   content = 8'h00;
          5'd12:   content = 8'h21;
          5'd13:   content = DEPTH_W[31:24];
          5'd14:   content = DEPTH_W[23:16];
          5'd15:   content = DEPTH_W[15:8];
          5'd16:   content = DEPTH_W[7:0];
          5'd17:   content = 8'h23;
          5'd18:   content = RATE_W[31:24];
          5'd19:   content = RATE_W[23:16];
          5'd20:   content = RATE_W[15:8];
          5'd21:   content = RATE_W[7:0];
          5'd22:   content = 8'h40;
          5'd23:   content = PROBES_B;
          5'd24:   content = 8'h41;
          5'd25:   content = PROTO_B;
          default: content = 8'h00;
        endcase
      end
`ifdef SUMP_WORD_RESP_EN
      RESP_WORD: begin
        case (index[1:0])
          2'd0:    content = word_reg[7:0];
          2'd1:    content = word_reg[15:8];
          2'd2:    content = word_reg[23:16];
          default: content = word_reg[31:24];
        endcase
      end
`endif
      default: content = 8'h00;
    endcase
  end

  always_comb begin
    last_index = 5'd0;
    case (sel)
      RESP_ID:   last_index = 5'd4;
      RESP_META: last_index = 5'd26;
`ifdef SUMP_WORD_RESP_EN
      RESP_WORD: last_index = 5'(WORD_BYTES - 1);
`endif
      default:   last_index = 5'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      sel           <= RESP_ID;
      index         <= 5'd0;
      abort_pending <= 1'b0;
      tx_byte       <= 8'h00;
      tx_start      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
`ifdef SUMP_WORD_RESP_EN
      word_reg      <= 32'h0;
`endif
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (req_valid) begin
              sel           <= resp_sel;
              index         <= 5'd0;
              abort_pending <= 1'b0;
              busy          <= 1'b1;
              state         <= ST_SEND;
`ifdef SUMP_WORD_RESP_EN
              word_reg      <= word_in;
`endif
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (abort) begin
            done    <= 1'b1;
            aborted <= 1'b1;
            state   <= ST_FIN;
          end else if (!tx_busy) begin
            tx_byte  <= content;
            tx_start <= 1'b1;
            state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (abort) abort_pending <= 1'b1;
          if (tx_busy) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!tx_busy) begin
            if (abort || abort_pending) begin
              done    <= 1'b1;
              aborted <= 1'b1;
              state   <= ST_FIN;
            end else if (index == last_index) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              index <= index + 5'd1;
              state <= ST_SEND;
            end
          end else if (abort) begin
            abort_pending <= 1'b1;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sump_response_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_sump_response_sender
// Brief    : Directed, scoreboarded bench for sump_response_sender.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sump_response_sender;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  resp_sel;
  logic [31:0] word_in;
  logic        abort;
  logic        tx_busy;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        busy;
  logic        done;
  logic        aborted;

  logic        model_busy = 1'b0;
  logic        tx_hold    = 1'b0;
  int          busy_len   = 10;

  int          checks = 0;
  int          passed = 0;
  int          n_starts = 0;
  int          n_done = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  exp_q[$];

  logic [7:0]  id_exp [5]    = '{8'h41, 8'h43, 8'h53, 8'h50, 8'h00};
  logic [7:0]  meta_exp [27] = '{8'h01, 8'h41, 8'h43, 8'h53, 8'h50, 8'h00,
                                 8'h02, 8'h31, 8'h2E, 8'h30, 8'h30, 8'h00,
                                 8'h21, 8'h00, 8'h00, 8'h80, 8'h00,
                                 8'h23, 8'h0B, 8'hEB, 8'hC2, 8'h00,
                                 8'h40, 8'h08, 8'h41, 8'h02, 8'h00};

  assign tx_busy = model_busy | tx_hold;

  sump_response_sender dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .resp_sel (resp_sel),
    .word_in  (word_in),
    .abort    (abort),
    .tx_busy  (tx_busy),
    .tx_byte  (tx_byte),
    .tx_start (tx_start),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // UART TX model: busy rises the cycle after tx_start and stays for busy_len cycles.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (tx_start) begin
        @(posedge clock);
        #1 model_busy = 1'b1;
        repeat (busy_len) @(posedge clock);
        #1 model_busy = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (tx_start) begin
      n_starts++;
      check("tx_start_back_to_back", prev_start, 0);
      check("tx_start_while_busy", tx_busy, 0);
      check("tx_start_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("tx_byte", tx_byte, exp_q.pop_front());
    end
    if (aborted) check("aborted_without_done", done, 1);
    if (done) n_done++;
    prev_start = tx_start;
  end

  task automatic request(input logic [1:0] sel, input logic [31:0] w);
    resp_sel = sel;
    word_in  = w;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (n_starts < n && k < budget) begin @(negedge clock); k++; end
    check(tag, n_starts >= n, 1);
  endtask

  task automatic wait_txbusy(input int budget, input string tag);
    int k = 0;
    while (!tx_busy && k < budget) begin @(negedge clock); k++; end
    check(tag, tx_busy, 1);
  endtask

  task automatic finish_req(input string tag, input int exp_starts, input logic exp_abort);
    int k = 0;
    while (!done && k < 3000) begin @(negedge clock); k++; end
    check({tag, "_done"}, done, 1);
    check({tag, "_aborted"}, aborted, exp_abort);
    check({tag, "_busy_at_done"}, busy, 1);
    @(negedge clock);
    check({tag, "_busy_after_done"}, busy, 0);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_start_count"}, n_starts, exp_starts);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic clear_counts();
    n_starts = 0;
    n_done   = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; resp_sel = 2'd0; word_in = 32'h0; abort = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // ID response with 10-cycle busy windows
    clear_counts(); busy_len = 10;
    foreach (id_exp[i]) exp_q.push_back(id_exp[i]);
    request(2'd0, 32'h0);
    check("id_busy_next_cycle", busy, 1);
    @(negedge clock);
    check("id_first_tx_start", tx_start, 1);
    finish_req("id", 5, 1'b0);

    // METADATA with one-cycle busy windows
    repeat (3) @(negedge clock);
    clear_counts(); busy_len = 1;
    foreach (meta_exp[i]) exp_q.push_back(meta_exp[i]);
    request(2'd1, 32'h0);
    finish_req("meta", 27, 1'b0);

    // WORD response
    repeat (3) @(negedge clock);
    clear_counts(); busy_len = 3;
`ifdef SUMP_WORD_RESP_EN
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
    request(2'd2, 32'hDEADBEEF);
    finish_req("word", 4, 1'b0);
`else
    request(2'd2, 32'hDEADBEEF);
    check("word_off_done", done, 1);
    check("word_off_busy", busy, 0);
    check("word_off_aborted", aborted, 0);
    repeat (10) @(negedge clock);
    check("word_off_starts", n_starts, 0);
    check("word_off_done_count", n_done, 1);
`endif

    // Reserved selector: immediate done, nothing sent
    repeat (3) @(negedge clock);
    clear_counts();
    request(2'd3, 32'h12345678);
    check("rsv_done", done, 1);
    check("rsv_busy", busy, 0);
    @(negedge clock);
    check("rsv_done_width", done, 0);
    repeat (8) @(negedge clock);
    check("rsv_starts", n_starts, 0);

    // Abort while the 3rd METADATA byte is in flight
    clear_counts(); busy_len = 10;
    for (int i = 0; i < 3; i++) exp_q.push_back(meta_exp[i]);
    request(2'd1, 32'h0);
    wait_starts(3, 500, "abort3_reach_third");
    wait_txbusy(50, "abort3_txbusy");
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    finish_req("abort3", 3, 1'b1);
    repeat (20) @(negedge clock);
    check("abort3_no_more_starts", n_starts, 3);

    // Abort while waiting in SEND: nothing is sent
    clear_counts(); tx_hold = 1'b1;
    request(2'd1, 32'h0);
    repeat (3) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_send_done", done, 1);
    finish_req("abort_send", 0, 1'b1);
    tx_hold = 1'b0;

    // tx_busy held high for 50 cycles; a second start is ignored
    repeat (3) @(negedge clock);
    clear_counts(); busy_len = 2; tx_hold = 1'b1;
    foreach (id_exp[i]) exp_q.push_back(id_exp[i]);
    request(2'd0, 32'h0);
    repeat (10) @(negedge clock);
    request(2'd1, 32'h0);
    repeat (39) @(negedge clock);
    check("hold_no_start", n_starts, 0);
    tx_hold = 1'b0;
    finish_req("hold", 5, 1'b0);
    repeat (30) @(negedge clock);
    check("hold_second_start_ignored", n_done, 1);
    check("hold_idle_busy", busy, 0);

    // Reset while in DRAIN, then a fresh ID request
    clear_counts(); busy_len = 10;
    foreach (id_exp[i]) exp_q.push_back(id_exp[i]);
    request(2'd0, 32'h0);
    wait_starts(2, 200, "rst_reach_second");
    wait_txbusy(50, "rst_txbusy");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_tx_byte", tx_byte, 8'h00);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_aborted", aborted, 0);
    reset = 1'b0;
    exp_q.delete();
    begin
      int k = 0;
      while (model_busy && k < 100) begin @(negedge clock); k++; end
    end
    repeat (5) @(negedge clock);
    check("mid_rst_silent", n_done, 0);
    check("mid_rst_no_start", n_starts, 2);
    clear_counts();
    foreach (id_exp[i]) exp_q.push_back(id_exp[i]);
    request(2'd0, 32'h0);
    finish_req("post_rst", 5, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sump_response_sender.md
# sump_response_sender

Parametrised SUMP/OLS response serialiser for the ACSP logic analyzer: on a single start request it streams one of several byte-oriented responses (device ID, metadata table, or a caller-supplied little-endian word) into the UART transmitter, one byte per transmitter handshake. It sits between the command decoder/controller and the UART TX block. It replaces the fixed-content metadata sender with:
- a metadata table built from parameters;
- a fully registered, race-free TX handshake;
- abort support.

## Interface
Parameters:
- `SAMPLE_DEPTH`, 32768 — sample memory bytes, reported under metadata key 0x21.
- `MAX_SAMPLE_RATE`, 200000000 — Hz, reported under key 0x23.
- `NUM_PROBES`, 8 — probe count, reported under key 0x40 (1..255).
- `PROTOCOL_VER`, 2 — reported under key 0x41.
- `WORD_BYTES`, 4 — bytes sent in WORD mode (1..4).

Ports:
- `clock` in 1 — sole clock, all logic on rising edge.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — request pulse; sampled only in IDLE.
- `resp_sel` in 2 — 0 = ID, 1 = METADATA, 2 = WORD, 3 = reserved (no-op). Sampled with `start`.
- `word_in` in 32 — WORD payload; latched with `start`.
- `abort` in 1 — terminate the current response.
- `tx_busy` in 1 — UART TX busy.
- `tx_byte` out 8 — byte to transmit.
- `tx_start` out 1 — one-cycle transmit strobe.
- `busy` out 1 — response in progress.
- `done` out 1 — one-cycle pulse on completion.
- `aborted` out 1 — one-cycle pulse, coincident with `done`, when the response ended via `abort`.

## Operation
Response contents. All multi-byte metadata values are big-endian.
- ID: 5 bytes: "A","C","S","P",0x00.
- METADATA: 27 bytes:
  - 0x01,"A","C","S","P",0x00
  - 0x02,"1",".","0","0",0x00
  - 0x21, SAMPLE_DEPTH[31:0]
  - 0x23, MAX_SAMPLE_RATE[31:0]
  - 0x40, NUM_PROBES[7:0]
  - 0x41, PROTOCOL_VER[7:0]
  - 0x00
- WORD: `word_in` bytes 0..WORD_BYTES-1, LSB first.
- Contents are computed combinationally from parameters and the byte index. No initial-block ROM.

State machine:
- IDLE:
  - `start` with resp_sel 0..2 → latch `resp_sel` and `word_in`, clear byte index, go to SEND.
  - `start` with resp_sel 3 → stay in IDLE, pulse `done` the next cycle.
- SEND: wait for `tx_busy`=0, then register `tx_byte`=content[index], pulse `tx_start`, go to ACK.
- ACK: wait for `tx_busy`=1, go to DRAIN.
- DRAIN: wait for `tx_busy`=0.
  - If index == last → FIN.
  - Otherwise index+1 → SEND.
- FIN: pulse `done`, go to IDLE.

Byte index is 5 bits. Last index is 4 for ID, 26 for METADATA, WORD_BYTES-1 for WORD. The index never wraps.

`abort` handling:
- In SEND, before `tx_start` → go to FIN immediately, with `aborted`=1 alongside `done`.
- In ACK or DRAIN → complete the in-flight byte, then go to FIN with `aborted`. No further bytes are sent.
- In IDLE → ignored.

`start` while `busy` is ignored.

`busy` is high in every state except IDLE. It falls the cycle after the `done` pulse.

## Timing
- Reset values: `tx_byte`=0x00, `tx_start`=0, `busy`=0, `done`=0, `aborted`=0; state IDLE, index 0. Reset mid-response aborts silently: no `done`, no `tx_start`.
- All outputs are registered.
- `start` at cycle N → `busy`=1 at N+1.
- First `tx_start` at N+2 if `tx_busy`=0 at N+1.
- `tx_byte` holds its value from its `tx_start` cycle until the next `tx_start`.
- `tx_start` is never high for two consecutive cycles.
- `tx_start` is never high while `tx_busy`=1.
- The TX block must raise `tx_busy` within any finite number of cycles after `tx_start`; ACK waits indefinitely.
- Minimum spacing of `tx_start` pulses is 4 cycles (SEND→ACK→DRAIN→SEND), with one-cycle busy windows.
- `done` is high exactly one cycle after the cycle where DRAIN sees `tx_busy`=0 on the last byte.
- Simultaneous `abort` and `tx_busy` fall in DRAIN → FIN with `aborted`=1.

## Configuration
- Macro `SUMP_WORD_RESP_EN`.
- Defined: WORD mode (resp_sel 2) is implemented as above.
- Undefined:
  - resp_sel 2 behaves like resp_sel 3 (immediate `done`, no bytes sent).
  - The `word_in` latch and WORD content mux are removed.
  - `word_in` remains a port and is ignored.

## Test plan
- ID, `tx_busy` pulsed 10 cycles per byte → `tx_byte` sequence 0x41,0x43,0x53,0x50,0x00; 5 `tx_start` pulses; `done` once; `aborted`=0.
- METADATA with defaults → 27 bytes. Bytes 12..16 = 0x21,0x00,0x00,0x80,0x00. Bytes 17..21 = 0x23,0x0B,0xEB,0xC2,0x00. Last byte 0x00.
- WORD, `word_in`=0xDEADBEEF, WORD_BYTES=4 → 0xEF,0xBE,0xAD,0xDE. With `SUMP_WORD_RESP_EN` undefined → zero `tx_start`, `done` 1 cycle after `busy`.
- `abort` asserted while the 3rd METADATA byte is in flight → 3rd byte completes, no 4th `tx_start`, `done`+`aborted` pulse.
- `tx_busy` held high at `start` for 50 cycles → no `tx_start` until it falls. Second `start` during the response is ignored.
- `reset` asserted in DRAIN → next cycle all outputs 0, IDLE. A fresh ID request then sends all 5 bytes from index 0.
